// File: rtl/sat_add_rr_scheduler_if.sv
// Requester/consumer bundle for the shared saturating adder.
// The master side drives operands and result backpressure; the slave side is the scheduler.
interface sat_add_rr_scheduler_if #(
    parameter int W = 4,
    parameter int N = 2
);
    localparam int ID_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   req_vld;
    logic [N-1:0]   req_rdy;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           res_vld;
    logic           res_rdy;
    logic [ID_W-1:0] res_id;
    logic [W-1:0]   res_sum;
    logic           res_sat;

    modport master (
        output req_vld, req_a, req_b, res_rdy,
        input  req_rdy, res_vld, res_id, res_sum, res_sat
    );

    modport slave (
        input  req_vld, req_a, req_b, res_rdy,
        output req_rdy, res_vld, res_id, res_sum, res_sat
    );
endinterface

// File: rtl/sat_add_rr_scheduler.sv
// Round-robin arbiter feeding one signed saturating adder through a 2-stage pipeline.
// Results carry the requester ID; clamped results consumed are counted in sat_cnt.
module sat_add_rr_scheduler #(
    parameter int W     = 4,
    parameter int N     = 2,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    sat_add_rr_scheduler_if.slave  bus,
    output logic [CNT_W-1:0]       sat_cnt
);
    localparam int ID_W = (N > 1) ? $clog2(N) : 1;

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] gnt_id;
    logic            found;
    logic [N-1:0]    gnt_oh;
    logic            adv;
    logic            can_load;
    logic            xfer;

    logic            s1_vld;
    logic [W-1:0]    s1_a;
    logic [W-1:0]    s1_b;
    logic [ID_W-1:0] s1_id;

    logic            s2_vld;
    logic [ID_W-1:0] s2_id;
    logic [W-1:0]    s2_sum;
    logic            s2_sat;

    logic [W-1:0]    t;
    logic            ovf;
    logic [W-1:0]    sum_c;

    // Search starts at the pointer and wraps, so the last winner gets lowest priority.
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && bus.req_vld[ID_W'((int'(ptr) + k) % N)]) begin
                found  = 1'b1;
                gnt_id = ID_W'((int'(ptr) + k) % N);
            end
        end
    end

    assign gnt_oh      = N'(1) << gnt_id;
    assign adv         = !s2_vld || bus.res_rdy;
    assign can_load    = adv && !rst;
    assign xfer        = can_load && found;
    assign bus.req_rdy = xfer ? gnt_oh : '0;

    always_comb begin
        t     = s1_a + s1_b;
        ovf   = (s1_a[W-1] == s1_b[W-1]) && (t[W-1] != s1_a[W-1]);
        sum_c = t;
        if (ovf) begin
            sum_c = s1_a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            s1_vld  <= 1'b0;
            s1_a    <= '0;
            s1_b    <= '0;
            s1_id   <= '0;
            s2_vld  <= 1'b0;
            s2_id   <= '0;
            s2_sum  <= '0;
            s2_sat  <= 1'b0;
            sat_cnt <= '0;
        end else begin
            if (xfer) begin
                ptr <= (int'(gnt_id) == N - 1) ? '0 : gnt_id + 1'b1;
            end
            // Both stages shift together so a drain and a fill can share one cycle.
            if (adv) begin
                s2_vld <= s1_vld;
                if (s1_vld) begin
                    s2_id  <= s1_id;
                    s2_sum <= sum_c;
                    s2_sat <= ovf;
                end
                s1_vld <= xfer;
                if (xfer) begin
                    s1_a  <= bus.req_a[gnt_id*W +: W];
                    s1_b  <= bus.req_b[gnt_id*W +: W];
                    s1_id <= gnt_id;
                end
            end
            if (s2_vld && bus.res_rdy && s2_sat && (sat_cnt != {CNT_W{1'b1}})) begin
                sat_cnt <= sat_cnt + 1'b1;
            end
        end
    end

    assign bus.res_vld = s2_vld;
    assign bus.res_id  = s2_id;
    assign bus.res_sum = s2_sum;
    assign bus.res_sat = s2_sat;
endmodule
